// File: rtl/io_input_port_pkg.sv
// io_pkg - shared constants for the memory-mapped board input port.
//   Register offsets (word offset taken from dataAdr[3:2]), STATUS bit
//   positions and the default debounce length (10 ms at 100 MHz).
package io_pkg;

  localparam logic [1:0] IO_STATUS = 2'd0;
  localparam logic [1:0] IO_DATAR  = 2'd1;
  localparam logic [1:0] IO_DATAL  = 2'd2;
  localparam logic [1:0] IO_LIVE   = 2'd3;

  localparam int ST_RDYR = 0;
  localparam int ST_RDYL = 1;
  localparam int ST_OVR  = 2;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 32'd1000000;

endpackage

// File: rtl/io_input_port_btn_debounce.sv
// btn_debounce - synchronizes one raw push button, debounces it and emits a
// one-cycle registered pulse on every debounced press (0->1).
//   clk    in   system clock, rising edge
//   reset  in   synchronous active-high reset
//   raw    in   asynchronous raw button level
//   db     out  debounced level
//   press  out  one-cycle pulse, the cycle after db rises
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db,
  output logic press
);

  // clog2(N) bits always hold N-1, the largest count ever reached.
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 32'd1);

  logic          sync1_r;
  logic          sync2_r;
  logic          db_r;
  logic          db_d_r;
  logic          press_r;
  logic [CW-1:0] cnt_r;

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
    end
  end

  // Stability counter: any return to the current debounced level restarts it,
  // so only N consecutive cycles at the new level flip db.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_r  <= 1'b0;
      cnt_r <= '0;
    end else if (sync2_r == db_r) begin
      cnt_r <= '0;
    end else if (cnt_r == CNT_LAST) begin
      db_r  <= sync2_r;
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  // Rising-edge detector on db; releases produce no pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_d_r  <= 1'b0;
      press_r <= 1'b0;
    end else begin
      db_d_r  <= db_r;
      press_r <= db_r & ~db_d_r;
    end
  end

  assign db    = db_r;
  assign press = press_r;

endmodule

// File: rtl/io_input_port.sv
// io_input_port - memory-mapped input responder for the single-cycle MIPS
// data bus. Debounces btnL/btnR, snapshots the switches on each press and
// exposes STATUS / DATAR / DATAL / LIVE registers to the CPU.
//   clk, reset        clock and synchronous active-high reset
//   sel, rd, wr       chip select and strobes (strobes qualified by sel)
//   addr[1:0]         word offset (dataAdr[3:2])
//   wdata[31:0]       write data (only STATUS bit 2 is writable, as clear)
//   rdata[31:0]       read data, combinational from registers, 0 when !sel
//   btnL, btnR        raw asynchronous push buttons
//   sw[15:0]          raw asynchronous slide switches
module io_input_port
  import io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        rd,
  input  logic        wr,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        btnL,
  input  logic        btnR,
  input  logic [15:0] sw
);

  logic [15:0] sw_sync1_r;
  logic [15:0] sw_sync2_r;
  logic [15:0] datar_r;
  logic [15:0] datal_r;
  logic        rdyr_r;
  logic        rdyl_r;
  logic        ovr_r;

  logic        dbr_s;
  logic        dbl_s;
  logic        pressr_s;
  logic        pressl_s;
  logic        rd_datar_s;
  logic        rd_datal_s;
  logic        ovr_clr_s;
  logic [31:0] status_s;
  logic        unused_ok_s;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_r (
    .clk   (clk),
    .reset (reset),
    .raw   (btnR),
    .db    (dbr_s),
    .press (pressr_s)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_l (
    .clk   (clk),
    .reset (reset),
    .raw   (btnL),
    .db    (dbl_s),
    .press (pressl_s)
  );

  assign rd_datar_s = sel & rd & (addr == IO_DATAR);
  assign rd_datal_s = sel & rd & (addr == IO_DATAL);
  assign ovr_clr_s  = sel & wr & (addr == IO_STATUS) & wdata[ST_OVR];

  // Debounced levels and the ignored write-data bits are intentionally unused.
  assign unused_ok_s = ^{wdata[31:3], wdata[1:0], dbr_s, dbl_s};

  // Two-flop synchronizer for the switches (not debounced).
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_sync1_r <= 16'h0000;
      sw_sync2_r <= 16'h0000;
    end else begin
      sw_sync1_r <= sw;
      sw_sync2_r <= sw_sync1_r;
    end
  end

  // Right channel: a press beats a same-cycle clearing read of DATAR.
  always_ff @(posedge clk) begin
    if (reset) begin
      datar_r <= 16'h0000;
      rdyr_r  <= 1'b0;
    end else if (pressr_s) begin
      datar_r <= sw_sync2_r;
      rdyr_r  <= 1'b1;
    end else if (rd_datar_s) begin
      rdyr_r  <= 1'b0;
    end else begin
      rdyr_r  <= rdyr_r;
    end
  end

  // Left channel: same priority as the right channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      datal_r <= 16'h0000;
      rdyl_r  <= 1'b0;
    end else if (pressl_s) begin
      datal_r <= sw_sync2_r;
      rdyl_r  <= 1'b1;
    end else if (rd_datal_s) begin
      rdyl_r  <= 1'b0;
    end else begin
      rdyl_r  <= rdyl_r;
    end
  end

  // Overflow flag: a press onto an unread value sets it, and that set
  // outranks a same-cycle software clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovr_r <= 1'b0;
    end else if ((pressr_s & rdyr_r) | (pressl_s & rdyl_r)) begin
      ovr_r <= 1'b1;
    end else if (ovr_clr_s) begin
      ovr_r <= 1'b0;
    end else begin
      ovr_r <= ovr_r;
    end
  end

  // STATUS word assembly.
  always_comb begin
    status_s          = 32'h0000_0000;
    status_s[ST_RDYR] = rdyr_r;
    status_s[ST_RDYL] = rdyl_r;
    status_s[ST_OVR]  = ovr_r;
  end

  // Read mux; valid in the same cycle as the strobe.
  always_comb begin
    rdata = 32'h0000_0000;
    if (sel) begin
      case (addr)
        IO_STATUS: rdata = status_s;
        IO_DATAR:  rdata = {16'h0000, datar_r};
        IO_DATAL:  rdata = {16'h0000, datal_r};
        IO_LIVE:   rdata = {16'h0000, sw_sync2_r};
        default:   rdata = 32'h0000_0000;
      endcase
    end else begin
      rdata = 32'h0000_0000;
    end
  end

endmodule

// File: doc/io_input_port.md
# io_input_port

Memory-mapped input responder for the single-cycle MIPS data bus. It debounces the left and right push buttons and snapshots the 16 slide switches on each debounced press. Software polls a status register and reads the latched values. It sits behind the data-memory address decoder, beside the seven-segment output port, and gives the CPU the read direction of the board I/O.

## Interface
- DEBOUNCE_CYCLES, default 1000000, is the number of consecutive cycles a synchronized button must hold a new level before the debounced level changes (10 ms at 100 MHz). Minimum value is 2.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- sel  in  1  chip select from the address decoder.
- rd  in  1  CPU read strobe; qualified by sel.
- wr  in  1  CPU write strobe; qualified by sel.
- addr  in  2  word offset, taken from dataAdr[3:2].
- wdata  in  32  CPU write data.
- rdata  out  32  read data; combinational from registers.
- btnL  in  1  raw left button, asynchronous.
- btnR  in  1  raw right button, asynchronous.
- sw  in  16  raw switches, asynchronous.

## Operation
- Synchronizers: btnL, btnR and sw each pass through a 2-flop synchronizer. Switches are not debounced.
- Debouncer (one per button):
  - Holds a debounced level db and a counter cnt.
  - If the synchronized level s equals db, cnt is set to 0.
  - Otherwise cnt increments.
  - When cnt == DEBOUNCE_CYCLES-1 and s != db, then db <= s and cnt <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes db.
- Press pulse: a registered one-cycle pulse, asserted the cycle after db goes 0→1. Releases produce no pulse.
- Register map, selected by addr:
  - 0 STATUS: bit0 rdyR, bit1 rdyL, bit2 ovr, bits 31:3 zero.
  - 1 DATAR: the switch value latched at the last R press, zero-extended.
  - 2 DATAL: the switch value latched at the last L press, zero-extended.
  - 3 LIVE: the current synchronized switches, zero-extended.
- R press pulse: DATAR <= synchronized sw and rdyR <= 1. If rdyR was already 1, ovr <= 1. The L press pulse behaves the same way with DATAL and rdyL.
- Read side effects (sel & rd): reading DATAR clears rdyR at the clock edge, and reading DATAL clears rdyL. Reading STATUS or LIVE has no side effect.
- Write (sel & wr & addr==0): if wdata[2] is 1, ovr is cleared. All other bits and offsets ignore writes.
- When sel is 0, rdata = 0 and rd/wr are ignored.
- Simultaneous events:
  - A press pulse in the same cycle as a clearing read of the same channel: the set wins. New data is latched, rdy stays 1, and ovr is set because rdy was 1.
  - An ovr-clear write in the same cycle as an overflowing press: ovr ends at 1.
  - Presses on both buttons in one cycle are handled independently.

## Timing
- Reset values: rdata=0 with sel low; DATAR, DATAL, rdyR, rdyL, ovr, db, cnt, pulses and synchronizer flops are all 0.
- Latency from a raw button held high continuously (change sampled at edge 0):
  - Synchronized level high after edge 2.
  - db high after edge 2+DEBOUNCE_CYCLES.
  - Pulse high during the following cycle.
  - rdy and DATA update at edge 4+DEBOUNCE_CYCLES.
- The switch value latched is the synchronized value present in the pulse cycle.
- Read data is valid in the same cycle as the strobe, which matches the single-cycle CPU. The rdy clear takes effect at the end of that cycle.
- Reset asserted mid-debounce or mid-press discards all state. A button held through reset must debounce again from cnt=0 after reset drops, and produces a press pulse.

## Structure
- Package io_pkg holds:
  - Offset constants IO_STATUS=2'd0, IO_DATAR=2'd1, IO_DATAL=2'd2, IO_LIVE=2'd3.
  - Status bit indices ST_RDYR=0, ST_RDYL=1, ST_OVR=2.
  - The DEBOUNCE_CYCLES default.
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES; ports clk, reset, raw, db, press) contains the synchronizer, counter and edge pulse. It is instantiated twice.
- Switch synchronizer, register file and bus mux live in io_input_port.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset: assert reset for 2 cycles with sw=16'hFFFF. With sel=1, addr=0, rdata=0; addr=3 reads 32'h0000FFFF after 2 cycles.
- Clean R press: sw=16'hA5C3, btnR held high. STATUS reads 32'h1 starting at edge 8. DATAR reads 32'h0000A5C3, and that read makes STATUS=0 the next cycle.
- Glitch rejection: btnR high for 3 cycles, then low. STATUS stays 0 indefinitely.
- Overflow: two R presses with sw=16'h0001 then 16'h0002 and no read between. STATUS=32'h5 and DATAR=32'h2. Writing wdata=32'h4 to addr 0 gives STATUS=32'h1.
- Collision: a DATAR read in the exact pulse cycle of a second press. Afterwards rdyR=1, ovr=1, and DATAR holds the new switch value.
- Deselect: sel=0 with rd=1 at addr 1 while rdyR=1. rdata=0 and rdyR is still 1.
